// File: rtl/tty_pkg.sv
// Shared constants, state encoding and screen-address helper for the console terminal.
package tty_pkg;

  localparam int unsigned TTY_COLS = 80;
  localparam int unsigned TTY_ROWS = 60;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    PUT,
    CLR_LINE,
    CLR_SCREEN
  } tty_state_t;

  // row*80 + col computed as row*64 + row*16 + col
  function automatic logic [12:0] cell_adr(input logic [5:0] row, input logic [6:0] col);
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, col};
  endfunction

endpackage

// File: rtl/console_tty.sv
// Text terminal: turns an ASCII byte stream into screen-RAM writes, keeping a cursor
// and clearing the next line (rather than scrolling) on line advance.
module console_tty
  import tty_pkg::*;
#(
  parameter int unsigned COLS = TTY_COLS,
  parameter int unsigned ROWS = TTY_ROWS
) (
  input  logic        clk_25mhz,
  input  logic        rst,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [12:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic        ack_i,
  output logic [6:0]  cur_col_o,
  output logic [5:0]  cur_row_o
);

  tty_state_t  state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [12:0] clr_q, clr_d;
  logic [7:0]  glyph_q, glyph_d;
  logic        adv_q, adv_d;

  logic        accept;
  logic        printable;
  logic [5:0]  row_inc;

  assign accept    = char_valid_i && char_ready_o;
  assign printable = (char_i >= 8'h20) && (char_i != 8'h7F);
  assign row_inc   = (row_q == 6'(ROWS - 1)) ? '0 : row_q + 6'd1;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      clr_q   <= '0;
      glyph_q <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      clr_q   <= clr_d;
      glyph_q <= glyph_d;
      adv_q   <= adv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    clr_d   = clr_q;
    glyph_d = glyph_q;
    adv_d   = adv_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            glyph_d = char_i;
            adv_d   = 1'b1;
            state_d = PUT;
          end else begin
            case (char_i)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d   = '0;
                row_d   = row_inc;
                clr_d   = cell_adr(row_inc, '0);
                state_d = CLR_LINE;
              end
              CH_BS: begin
                if (col_q != '0) begin
                  col_d   = col_q - 7'd1;
                  glyph_d = CH_SPACE;
                  adv_d   = 1'b0;
                  state_d = PUT;
                end
              end
              CH_FF: begin
                col_d   = '0;
                row_d   = '0;
                clr_d   = '0;
                state_d = CLR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end
      // Printable glyphs advance the cursor only once the write is acknowledged;
      // backspace has already moved it and just blanks the cell.
      PUT: begin
        if (ack_i) begin
          state_d = IDLE;
          if (adv_q) begin
            if (col_q == 7'(COLS - 1)) begin
              col_d   = '0;
              row_d   = row_inc;
              clr_d   = cell_adr(row_inc, '0);
              state_d = CLR_LINE;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
        end
      end
      CLR_LINE: begin
        if (ack_i) begin
          if (clr_q == cell_adr(row_q, 7'(COLS - 1))) state_d = IDLE;
          else clr_d = clr_q + 13'd1;
        end
      end
      CLR_SCREEN: begin
        if (ack_i) begin
          if (clr_q == 13'(COLS * ROWS - 1)) state_d = IDLE;
          else clr_d = clr_q + 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stb_o = (state_q != IDLE);
    we_o  = stb_o;
    sel_o = stb_o ? 4'b0001 : 4'b0000;
    adr_o = '0;
    dat_o = '0;
    case (state_q)
      PUT: begin
        adr_o = cell_adr(row_q, col_q);
        dat_o = {24'b0, glyph_q};
      end
      CLR_LINE, CLR_SCREEN: begin
        adr_o = clr_q;
        dat_o = {24'b0, CH_SPACE};
      end
      default: ;
    endcase
  end

  assign char_ready_o = (state_q == IDLE) && !rst;
  assign cur_col_o    = col_q;
  assign cur_row_o    = row_q;

endmodule

// File: tb/tb_console_tty.sv
// Self-checking bench for console_tty: directed cursor/clear scenarios plus random
// character streams against a screen-level reference model.
module tb_console_tty;

  logic        clk_25mhz;
  logic        rst;
  logic [7:0]  char_i;
  logic        char_valid_i;
  logic        char_ready_o;
  logic [12:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        stb_o;
  logic        ack_i;
  logic [6:0]  cur_col_o;
  logic [5:0]  cur_row_o;

  logic ack_force, ack_lvl, rnd_ack;

  int total = 0;
  int bad   = 0;

  int mcol, mrow;
  int eq_adr[$];
  int eq_dat[$];
  int wr_cnt = 0;

  assign ack_i = stb_o && (ack_force ? ack_lvl : rnd_ack);

  console_tty #(.COLS(80), .ROWS(60)) dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .char_i      (char_i),
    .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .sel_o       (sel_o),
    .we_o        (we_o),
    .stb_o       (stb_o),
    .ack_i       (ack_i),
    .cur_col_o   (cur_col_o),
    .cur_row_o   (cur_row_o)
  );

  initial begin
    clk_25mhz = 1'b0;
    forever #20 clk_25mhz = ~clk_25mhz;
  end

  initial rnd_ack = 1'b1;
  always @(posedge clk_25mhz) begin
    #1 rnd_ack = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: cursor rules and the list of writes each character must produce.
  function automatic void push_wr(input int a, input int d);
    eq_adr.push_back(a);
    eq_dat.push_back(d);
  endfunction

  function automatic void next_line();
    mrow = (mrow + 1) % 60;
    for (int i = 0; i < 80; i++) push_wr(mrow * 80 + i, 32'h20);
  endfunction

  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h20 && c != 8'h7F) begin
      push_wr(mrow * 80 + mcol, int'(c));
      mcol++;
      if (mcol == 80) begin
        mcol = 0;
        next_line();
      end
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h0A) begin
      mcol = 0;
      next_line();
    end else if (c == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push_wr(mrow * 80 + mcol, 32'h20);
      end
    end else if (c == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      for (int i = 0; i < 4800; i++) push_wr(i, 32'h20);
    end
  endfunction

  // Bus monitor: a write completes on the edge following a negedge that sees stb&&ack.
  logic        pend = 1'b0;
  logic [44:0] held;
  always @(negedge clk_25mhz) begin
    if (stb_o) begin
      if (pend) chk("bus_hold", {adr_o, dat_o}, held);
      chk("wr_sel_we", {sel_o, we_o}, {4'b0001, 1'b1});
      if (ack_i) begin
        wr_cnt++;
        chk("wr_expected", eq_adr.size() != 0, 1);
        if (eq_adr.size() != 0) begin
          chk("wr_adr", adr_o, eq_adr[0]);
          chk("wr_dat", dat_o, eq_dat[0]);
          void'(eq_adr.pop_front());
          void'(eq_dat.pop_front());
        end
      end
      pend = !ack_i;
      held = {adr_o, dat_o};
    end else begin
      pend = 1'b0;
      chk("idle_sel_we", {sel_o, we_o}, 5'b0);
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!char_ready_o && w < 10000) begin
      @(negedge clk_25mhz);
      w++;
    end
    chk("ready_wait", char_ready_o, 1);
  endtask

  task automatic send_char(input logic [7:0] c, output int lat, output logic stb1);
    wait_ready();
    char_i       = c;
    char_valid_i = 1'b1;
    @(posedge clk_25mhz);
    #1 char_valid_i = 1'b0;
    model_char(c);
    lat  = 0;
    stb1 = 1'b0;
    do begin
      @(negedge clk_25mhz);
      lat++;
      if (lat == 1) stb1 = stb_o;
    end while (!char_ready_o && lat < 10000);
    chk("cur_col", cur_col_o, mcol);
    chk("cur_row", cur_row_o, mrow);
    chk("wr_left", eq_adr.size(), 0);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    logic [7:0] v;
    r = $urandom_range(0, 99);
    if (r < 50) v = 8'($urandom_range(32, 126));
    else if (r < 60) v = 8'($urandom_range(128, 255));
    else if (r < 70) v = 8'h0D;
    else if (r < 80) v = 8'h0A;
    else if (r < 92) v = 8'h08;
    else begin
      v = 8'($urandom_range(0, 31));
      if (v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D) v = 8'h7F;
    end
    return v;
  endfunction

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, snap;
    logic s1;
    rst = 1'b1;
    char_valid_i = 1'b0;
    char_i = '0;
    ack_force = 1'b1;
    ack_lvl = 1'b1;
    mcol = 0;
    mrow = 0;
    repeat (3) @(negedge clk_25mhz);
    chk("rst_bus", {stb_o, we_o, sel_o, adr_o, dat_o}, 32'h0);
    chk("rst_ready", char_ready_o, 0);
    chk("rst_cursor", {cur_row_o, cur_col_o}, 0);
    rst = 1'b0;

    send_char(8'h41, lat, s1);
    chk("A_stb_n1", s1, 1);
    chk("A_latency", lat, 2);
    chk("A_col", cur_col_o, 1);

    for (int i = 0; i < 78; i++) send_char(8'($urandom_range(33, 126)), lat, s1);
    send_char(8'h5A, lat, s1);
    chk("Z_wrap_latency", lat, 82);
    chk("Z_cursor", {cur_row_o, cur_col_o}, {6'd1, 7'd0});

    for (int i = 0; i < 58; i++) begin
      send_char(8'h0A, lat, s1);
      if (i == 0) chk("LF_latency", lat, 81);
    end
    chk("row59", cur_row_o, 59);
    send_char(8'h0A, lat, s1);
    chk("LF_row_wrap", {cur_row_o, cur_col_o}, 0);

    send_char(8'h0A, lat, s1);
    send_char(8'h0A, lat, s1);
    for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i), lat, s1);
    send_char(8'h08, lat, s1);
    chk("BS_latency", lat, 2);
    chk("BS_cursor", {cur_row_o, cur_col_o}, {6'd2, 7'd4});

    send_char(8'h0D, lat, s1);
    chk("CR_latency", lat, 1);
    snap = wr_cnt;
    send_char(8'h08, lat, s1);
    chk("BS0_latency", lat, 1);
    chk("BS0_stb", s1, 0);
    chk("BS0_writes", wr_cnt - snap, 0);

    // Form feed with the first write stalled for three cycles
    ack_lvl = 1'b0;
    wait_ready();
    char_i = 8'h0C;
    char_valid_i = 1'b1;
    @(posedge clk_25mhz);
    #1 char_valid_i = 1'b0;
    model_char(8'h0C);
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_25mhz);
      lat++;
      chk("FF_hold0", {stb_o, adr_o}, {1'b1, 13'd0});
      if (k == 2) begin
        @(posedge clk_25mhz);
        #1 ack_lvl = 1'b1;
      end
    end
    while (!char_ready_o && lat < 10000) begin
      @(negedge clk_25mhz);
      lat++;
    end
    chk("FF_latency", lat, 4804);
    chk("FF_cursor", {cur_row_o, cur_col_o}, 0);
    chk("FF_wr_left", eq_adr.size(), 0);

    ack_force = 1'b0;
    for (int i = 0; i < 300; i++) send_char(rand_char(), lat, s1);

    // Reset in the middle of a screen clear
    wait_ready();
    char_i = 8'h0C;
    char_valid_i = 1'b1;
    @(posedge clk_25mhz);
    #1 char_valid_i = 1'b0;
    model_char(8'h0C);
    repeat (150) @(negedge clk_25mhz);
    chk("pre_rst_busy", stb_o, 1);
    #5 rst = 1'b1;
    #1;
    chk("rst_async_stb", stb_o, 0);
    chk("rst_async_ready", char_ready_o, 0);
    chk("rst_async_cursor", {cur_row_o, cur_col_o}, 0);
    eq_adr.delete();
    eq_dat.delete();
    mcol = 0;
    mrow = 0;
    repeat (3) @(negedge clk_25mhz);
    rst = 1'b0;
    snap = wr_cnt;
    repeat (20) @(negedge clk_25mhz);
    chk("post_rst_writes", wr_cnt - snap, 0);
    chk("post_rst_stb", stb_o, 0);
    chk("post_rst_ready", char_ready_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
